// File: rtl/vec3_alu_if.sv
// vec3_alu_if: operation / result handshake bundle for the vec3 ALU pipeline.
//
// Parameters:
//   WIDTH - signed component width (two's complement)
//   TAG_W - width of the opaque user tag
//
// Signals:
//   in_valid/in_ready   operation handshake (producer -> unit)
//   in_op               opcode: 0 ADD, 1 SUB, 2 DOT, 3 CROSS, 4 SCALE, 5-7 reserved
//   in_x, in_y          vector operands, component i at [i*WIDTH +: WIDTH]
//   in_a                scalar operand for SCALE
//   in_tag              tag travelling with the operation
//   out_valid/out_ready result handshake (unit -> consumer)
//   out_v               result vector, same packing as in_x
//   out_tag             tag of the result
//   out_err             result came from a reserved opcode
//
// Modports: master = producer/consumer side, slave = the ALU.
interface vec3_alu_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [3*WIDTH-1:0]   in_x;
    logic [3*WIDTH-1:0]   in_y;
    logic [WIDTH-1:0]     in_a;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [3*WIDTH-1:0]   out_v;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_err;

    modport master (
        output in_valid, in_op, in_x, in_y, in_a, in_tag, out_ready,
        input  in_ready, out_valid, out_v, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_x, in_y, in_a, in_tag, out_ready,
        output in_ready, out_valid, out_v, out_tag, out_err
    );
endinterface

// File: rtl/vec3_alu_pipe.sv
// vec3_alu_pipe: 3-stage pipelined fixed-point 3-vector ALU
// (ADD, SUB, DOT, CROSS, SCALE) with a valid/ready handshake.
//
// Parameters:
//   WIDTH  - signed component width
//   Q_BITS - fractional bits; products are arithmetically shifted right by Q_BITS
//   TAG_W  - user tag width
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset; clears all valid bits and the output register
//   bus   - vec3_alu_if.slave (operation in, result out)
//
// Stages: S1 registers the six products (and the ADD/SUB sums), S2 registers the
// combined/shifted wide components, S3 is the output register. All stages advance
// together when the output register is empty or being drained.
//
// Build option: define VEC3_ALU_SAT_EN to saturate each component to the WIDTH range
// before the output register; otherwise the low WIDTH bits are kept (wrap).
module vec3_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int Q_BITS = 16,
    parameter int TAG_W  = 4
) (
    input  logic      clk,
    input  logic      reset,
    vec3_alu_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 2;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_DOT   = 3'd2;
    localparam logic [2:0] OP_CROSS = 3'd3;
    localparam logic [2:0] OP_SCALE = 3'd4;

    typedef logic signed [WIDTH-1:0] comp_t;
    typedef logic signed [WIDTH:0]   lin_t;
    typedef logic signed [PW-1:0]    prod_t;
    typedef logic signed [PW:0]      diff_t;
    typedef logic signed [SW-1:0]    wide_t;

`ifdef VEC3_ALU_SAT_EN
    localparam wide_t CMAX = wide_t'({1'b0, {(WIDTH-1){1'b1}}});
    localparam wide_t CMIN = -CMAX - wide_t'(1);
`endif

    // Reduce a wide component to WIDTH bits (clamp or wrap depending on build).
    function automatic comp_t fit(input wide_t v);
`ifdef VEC3_ALU_SAT_EN
        if (v > CMAX)
            return comp_t'(CMAX);
        else if (v < CMIN)
            return comp_t'(CMIN);
        else
            return comp_t'(v);
`else
        return comp_t'(v);
`endif
    endfunction

    logic adv;
    logic vld_p1, vld_p2, vld_p3;

    // A single stall signal freezes every stage; in_ready never looks at in_valid.
    assign adv          = !vld_p3 || bus.out_ready;
    assign bus.in_ready = adv;

    comp_t x [3];
    comp_t y [3];
    comp_t a;

    assign a = comp_t'(bus.in_a);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            x[i] = comp_t'(bus.in_x[i*WIDTH +: WIDTH]);
            y[i] = comp_t'(bus.in_y[i*WIDTH +: WIDTH]);
        end
    end

    // Multiplier operand routing: pa = ma*mb, pb = mc*md. CROSS needs both
    // products per component; DOT and SCALE use only pa.
    comp_t ma [3];
    comp_t mb [3];
    comp_t mc [3];
    comp_t md [3];
    lin_t  lin [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ma[i] = x[i];
            mb[i] = y[i];
            mc[i] = '0;
            md[i] = '0;
            if (bus.in_op == OP_SUB)
                lin[i] = lin_t'(x[i]) - lin_t'(y[i]);
            else
                lin[i] = lin_t'(x[i]) + lin_t'(y[i]);
        end
        case (bus.in_op)
            OP_CROSS: begin
                ma[0] = x[1]; mb[0] = y[2]; mc[0] = x[2]; md[0] = y[1];
                ma[1] = x[2]; mb[1] = y[0]; mc[1] = x[0]; md[1] = y[2];
                ma[2] = x[0]; mb[2] = y[1]; mc[2] = x[1]; md[2] = y[0];
            end
            OP_SCALE: begin
                for (int i = 0; i < 3; i++)
                    mb[i] = a;
            end
            default: ;
        endcase
    end

    // ---- S1: products ----
    prod_t            pa_p1 [3];
    prod_t            pb_p1 [3];
    lin_t             lin_p1 [3];
    logic [2:0]       op_p1;
    logic [TAG_W-1:0] tag_p1;

    // Combine step: CROSS differences need one extra bit, the DOT sum two.
    wide_t comb_w [3];
    diff_t diff [3];
    logic  err_c;

    always_comb begin
        err_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            diff[i]   = diff_t'(pa_p1[i]) - diff_t'(pb_p1[i]);
            comb_w[i] = '0;
        end
        case (op_p1)
            OP_ADD, OP_SUB: begin
                for (int i = 0; i < 3; i++)
                    comb_w[i] = wide_t'(lin_p1[i]);
            end
            OP_DOT: begin
                comb_w[0] = wide_t'(pa_p1[0] >>> Q_BITS)
                          + wide_t'(pa_p1[1] >>> Q_BITS)
                          + wide_t'(pa_p1[2] >>> Q_BITS);
            end
            OP_CROSS: begin
                for (int i = 0; i < 3; i++)
                    comb_w[i] = wide_t'(diff[i] >>> Q_BITS);
            end
            OP_SCALE: begin
                for (int i = 0; i < 3; i++)
                    comb_w[i] = wide_t'(pa_p1[i] >>> Q_BITS);
            end
            default: err_c = 1'b1;
        endcase
    end

    // ---- S2: combine/shift ----
    wide_t            wide_p2 [3];
    logic [TAG_W-1:0] tag_p2;
    logic             err_p2;

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < 3; i++) begin
                pa_p1[i]   <= prod_t'(ma[i]) * prod_t'(mb[i]);
                pb_p1[i]   <= prod_t'(mc[i]) * prod_t'(md[i]);
                lin_p1[i]  <= lin[i];
                wide_p2[i] <= comb_w[i];
            end
            op_p1  <= bus.in_op;
            tag_p1 <= bus.in_tag;
            tag_p2 <= tag_p1;
            err_p2 <= err_c;
        end
    end

    // ---- S3: output register ----
    logic [3*WIDTH-1:0] v_p3;
    logic [TAG_W-1:0]   tag_p3;
    logic               err_p3;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            v_p3   <= '0;
            tag_p3 <= '0;
            err_p3 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= bus.in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                for (int i = 0; i < 3; i++)
                    v_p3[i*WIDTH +: WIDTH] <= fit(wide_p2[i]);
                tag_p3 <= tag_p2;
                err_p3 <= err_p2;
            end
        end
    end

    assign bus.out_valid = vld_p3;
    assign bus.out_v     = v_p3;
    assign bus.out_tag   = tag_p3;
    assign bus.out_err   = err_p3;
endmodule

// File: tb/tb_vec3_alu_pipe.sv
// tb_vec3_alu_pipe: self-checking bench for vec3_alu_pipe (WIDTH=32, Q_BITS=16, TAG_W=4).
// Directed cases plus randomized traffic with random backpressure, scored against an
// exact-arithmetic reference model (128-bit math, then wrap or clamp to 32 bits).
module tb_vec3_alu_pipe;
    localparam int W = 32;
    localparam int Q = 16;

    typedef logic signed [127:0] s_t;

    typedef struct {
        logic [95:0] v;
        logic [3:0]  tag;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vec3_alu_if #(.WIDTH(W), .TAG_W(4)) bus ();

    vec3_alu_pipe #(.WIDTH(W), .Q_BITS(Q), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_emit = 0;
    int          last_lat = 0;
    logic [95:0] last_v;
    logic [3:0]  last_tag;
    logic        last_err;
    exp_t        q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer math on the components, then reduce to 32 bits.
    function automatic logic [95:0] model_v(input logic [2:0] op, input logic [95:0] xv,
                                            input logic [95:0] yv, input logic [31:0] av);
        s_t x [3];
        s_t y [3];
        s_t r [3];
        s_t a;
        logic [95:0] res;
`ifdef VEC3_ALU_SAT_EN
        s_t hi;
        s_t lo;
        hi = s_t'(32'sh7FFFFFFF);
        lo = -hi - s_t'(1);
`endif
        a = s_t'($signed(av));
        for (int i = 0; i < 3; i++) begin
            x[i] = s_t'($signed(xv[i*W +: W]));
            y[i] = s_t'($signed(yv[i*W +: W]));
            r[i] = '0;
        end
        case (op)
            3'd0: for (int i = 0; i < 3; i++) r[i] = x[i] + y[i];
            3'd1: for (int i = 0; i < 3; i++) r[i] = x[i] - y[i];
            3'd2: r[0] = ((x[0] * y[0]) >>> Q) + ((x[1] * y[1]) >>> Q) + ((x[2] * y[2]) >>> Q);
            3'd3: begin
                r[0] = (x[1] * y[2] - x[2] * y[1]) >>> Q;
                r[1] = (x[2] * y[0] - x[0] * y[2]) >>> Q;
                r[2] = (x[0] * y[1] - x[1] * y[0]) >>> Q;
            end
            3'd4: for (int i = 0; i < 3; i++) r[i] = (x[i] * a) >>> Q;
            default: ;
        endcase
        for (int i = 0; i < 3; i++) begin
`ifdef VEC3_ALU_SAT_EN
            if (r[i] > hi) r[i] = hi;
            else if (r[i] < lo) r[i] = lo;
`endif
            res[i*W +: W] = r[i][31:0];
        end
        return res;
    endfunction

    function automatic logic [31:0] rnd_comp();
        logic [31:0] edge_v [4];
        edge_v[0] = 32'h7FFFFFFF;
        edge_v[1] = 32'h80000000;
        edge_v[2] = 32'hFFFFFFFF;
        edge_v[3] = 32'h00000001;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom_range(0, 524288) - 32'd262144;
            2:       return edge_v[$urandom_range(0, 3)];
            default: return 32'd0;
        endcase
    endfunction

    // One clock cycle: called just after a negedge with inputs already driven.
    // Samples the handshake, scores results, then moves to the next negedge.
    task automatic step();
        exp_t e;
        #1;
        if (reset) begin
            q.delete();
        end else begin
            check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("out_v", bus.out_v, q[0].v);
                    check("out_tag", bus.out_tag, q[0].tag);
                    check("out_err", bus.out_err, q[0].err);
                    if (bus.out_ready) begin
                        e = q.pop_front();
                        last_lat = cyc - e.acc;
                    end
                end
                if (bus.out_ready) begin
                    last_v   = bus.out_v;
                    last_tag = bus.out_tag;
                    last_err = bus.out_err;
                    n_emit++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.v   = model_v(bus.in_op, bus.in_x, bus.in_y, bus.in_a);
                e.tag = bus.in_tag;
                e.err = (bus.in_op > 3'd4);
                e.acc = cyc;
                q.push_back(e);
                n_acc++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_in(input logic [2:0] op, input logic [31:0] x0, input logic [31:0] x1,
                          input logic [31:0] x2, input logic [31:0] y0, input logic [31:0] y1,
                          input logic [31:0] y2, input logic [31:0] a, input logic [3:0] tag);
        bus.in_op  = op;
        bus.in_x   = {x2, x1, x0};
        bus.in_y   = {y2, y1, y0};
        bus.in_a   = a;
        bus.in_tag = tag;
    endtask

    task automatic send();
        int n0;
        int g;
        n0 = n_acc;
        g  = 0;
        bus.in_valid = 1'b1;
        while (n_acc == n0 && g < 50) begin
            step();
            g++;
        end
        if (n_acc == n0) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n0;
        int g;
        n0 = n_emit;
        g  = 0;
        bus.out_ready = 1'b1;
        while (n_emit == n0 && g < 20) begin
            step();
            g++;
        end
        if (n_emit == n0) check("wait_out_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, k, base_e, acc_last, emit_last, na, ne;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_in(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_v", bus.out_v, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // CROSS unit vectors: x cross y = z, latency 3
        bus.out_ready = 1'b1;
        set_in(3'd3, 32'd65536, 0, 0, 0, 32'd65536, 0, 0, 4'd3);
        send();
        wait_out();
        check("cross_v", last_v, {32'd65536, 32'd0, 32'd0});
        check("cross_tag", last_tag, 4'd3);
        check("cross_lat", last_lat, 3);

        // DOT (1,2,3).(4,5,6) = 32.0
        set_in(3'd2, 32'd65536, 32'd131072, 32'd196608, 32'd262144, 32'd327680, 32'd393216, 0, 4'd5);
        send();
        wait_out();
        check("dot_v", last_v, {32'd0, 32'd0, 32'd2097152});

        // SCALE by 0.5, then a reserved opcode right behind it
        set_in(3'd4, 32'd131072, 32'hFFFD0000, 32'd262144, $urandom, $urandom, $urandom, 32'd32768, 4'd6);
        send();
        set_in(3'd6, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 4'd7);
        send();
        wait_out();
        check("scale_v", last_v, {32'd131072, 32'hFFFE8000, 32'd65536});
        check("scale_err", last_err, 0);
        wait_out();
        check("rsvd_v", last_v, 96'd0);
        check("rsvd_err", last_err, 1);

        // Positive overflow on ADD
        set_in(3'd0, 32'h7FFFFFFF, 0, 0, 32'd1, 0, 0, 0, 4'd1);
        send();
        wait_out();
`ifdef VEC3_ALU_SAT_EN
        check("add_ovf", last_v[31:0], 32'h7FFFFFFF);
`else
        check("add_ovf", last_v[31:0], 32'h80000000);
`endif

        // Zero operands give zero for every opcode
        for (int op = 0; op < 8; op++) begin
            set_in(3'(op), 0, 0, 0, 0, 0, 0, 0, 4'(op));
            send();
            wait_out();
            check("zero_v", last_v, 96'd0);
        end

        // Back-to-back ADDs with out_ready low for cycles 3..6
        sent      = 0;
        k         = 0;
        base_e    = n_emit;
        acc_last  = -1;
        emit_last = -1;
        while ((sent < 8 || n_emit - base_e < 8) && k < 40) begin
            bus.in_valid = (sent < 8);
            set_in(3'd0, rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), 0, 4'(sent));
            bus.out_ready = !(k >= 3 && k <= 6);
            #1;
            if (k >= 3 && k <= 6) check("bp_in_ready_low", bus.in_ready, 0);
            na = n_acc;
            ne = n_emit;
            step();
            if (n_acc != na) begin
                sent++;
                acc_last = k;
            end
            if (n_emit != ne) emit_last = k;
            k++;
        end
        bus.in_valid = 1'b0;
        check("bp_last_accept", acc_last, 11);
        check("bp_last_emit", emit_last, 14);
        check("bp_last_tag", last_tag, 4'd7);

        // Reset with the pipe full: nothing stale may emerge afterwards
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(3'd0, rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), 0, 4'(i + 10));
            bus.in_valid = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_tag", bus.out_tag, 0);
        repeat (6) step();
        set_in(3'd1, 32'd5, 32'd6, 32'd7, 32'd1, 32'd2, 32'd3, 0, 4'd9);
        send();
        wait_out();
        check("post_rst_lat", last_lat, 3);
        check("post_rst_tag", last_tag, 4'd9);
        check("post_rst_v", last_v, {32'd4, 32'd4, 32'd4});

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            set_in(3'($urandom_range(0, 7)), rnd_comp(), rnd_comp(), rnd_comp(),
                   rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), 4'($urandom_range(0, 15)));
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) step();
        check("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
